forward_stall_unit: RTL

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

---
 rtl/forward_stall_if.sv | 53 +++++
 rtl/forward_stall_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/forward_stall_if.sv
// forward_stall_if -- pipeline-side bundle for the forwarding / stall unit.
//
// Carries the ID/EX/MEM/WB hazard-relevant fields into the unit and the
// forwarding selects, stall/bubble controls and multi-cycle status back out.
//   master : the pipeline (drives stage fields, observes controls)
//   slave  : forward_stall_unit
interface forward_stall_if #(
  parameter int AW   = 5,
  parameter int NSRC = 2
);
  // ID stage
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC-1:0]    id_src_used;
  logic               id_mc;
  // EX stage
  logic [NSRC*AW-1:0] ex_src;
  logic               ex_regwr;
  logic               ex_memread;
  logic [AW-1:0]      ex_waddr;
  logic               ex_mc_start;
  // MEM stage
  logic               mem_regwr;
  logic [AW-1:0]      mem_waddr;
  logic [AW-1:0]      mem_rt;
  // WB stage
  logic               wb_regwr;
  logic [AW-1:0]      wb_waddr;
  logic [1:0]         wb_memtoreg;
  // Controls back to the pipeline
  logic [2*NSRC-1:0]  fwd_sel;
  logic               fwd_store;
  logic               stall;
  logic               bubble;
  logic               mc_busy;
  logic               mc_done;
  logic [15:0]        stall_cnt;

  modport master (
    output id_src, id_src_used, id_mc,
    output ex_src, ex_regwr, ex_memread, ex_waddr, ex_mc_start,
    output mem_regwr, mem_waddr, mem_rt,
    output wb_regwr, wb_waddr, wb_memtoreg,
    input  fwd_sel, fwd_store, stall, bubble, mc_busy, mc_done, stall_cnt
  );

  modport slave (
    input  id_src, id_src_used, id_mc,
    input  ex_src, ex_regwr, ex_memread, ex_waddr, ex_mc_start,
    input  mem_regwr, mem_waddr, mem_rt,
    input  wb_regwr, wb_waddr, wb_memtoreg,
    output fwd_sel, fwd_store, stall, bubble, mc_busy, mc_done, stall_cnt
  );
endinterface

// File: rtl/forward_stall_unit.sv
// forward_stall_unit -- operand forwarding and hazard stall control for a
// five-stage pipeline with one multi-cycle execution unit.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : forward_stall_if.slave
//            fwd_sel   - per EX operand: 00 regfile, 01 EX/MEM, 10 MEM/WB
//            fwd_store - WB load data replaces the MEM store operand
//            stall     - hold PC and IF/ID
//            bubble    - insert NOP into ID/EX
//            mc_busy   - multi-cycle unit occupied
//            mc_done   - one-cycle pulse, multi-cycle result ready
//            stall_cnt - saturating count of stalled cycles
module forward_stall_unit #(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int MCLAT = 4   // 2..15
) (
  input  logic          clk,
  input  logic          reset,
  forward_stall_if.slave bus
);

  localparam int            CW      = 4;
  localparam logic [CW-1:0] MC_LOAD = CW'(MCLAT - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MCBUSY = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  mc_dest_q, mc_dest_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;

  logic [2*NSRC-1:0] fwd_sel;
  logic              fwd_store;
  logic              load_use;
  logic              mc_hazard;
  logic              stall_raw;
  logic              mc_busy;
  logic              mc_done;

  // ---------------------------------------------------------------------
  // Forwarding: purely combinational. EX/MEM is the younger result and
  // wins over MEM/WB; register 0 is hardwired and never forwarded.
  // ---------------------------------------------------------------------
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.mem_regwr && (bus.mem_waddr != '0) &&
          (bus.mem_waddr == bus.ex_src[i*AW +: AW]))
        fwd_sel[2*i +: 2] = 2'b01;
      else if (bus.wb_regwr && (bus.wb_waddr != '0) &&
               (bus.wb_waddr == bus.ex_src[i*AW +: AW]))
        fwd_sel[2*i +: 2] = 2'b10;
    end
  end

  assign fwd_store = (bus.wb_memtoreg == 2'b01) && bus.wb_regwr &&
                     (bus.mem_rt != '0) && (bus.wb_waddr == bus.mem_rt);

  // ---------------------------------------------------------------------
  // Hazard detection against the instruction sitting in ID.
  // ---------------------------------------------------------------------
  always_comb begin
    load_use  = 1'b0;
    mc_hazard = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.id_src_used[i] && bus.ex_memread && bus.ex_regwr &&
          (bus.ex_waddr != '0) && (bus.ex_waddr == bus.id_src[i*AW +: AW]))
        load_use = 1'b1;
      if (bus.id_src_used[i] && (mc_dest_q != '0) &&
          (mc_dest_q == bus.id_src[i*AW +: AW]))
        mc_hazard = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM: next state, counter, destination latch and outputs.
  // ---------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_dest_d = mc_dest_q;
    stall_raw = 1'b0;
    mc_busy   = 1'b0;
    mc_done   = 1'b0;

    unique case (state_q)
      RUN: begin
        stall_raw = load_use;
        if (bus.ex_mc_start) begin
          cnt_d     = MC_LOAD;
          mc_dest_d = bus.ex_waddr;
          state_d   = MCBUSY;
        end else if (load_use) begin
          state_d = LSTALL;
        end
      end

      // The bubble inserted last cycle now occupies EX, so the dependent
      // instruction proceeds: exactly one bubble of penalty.
      LSTALL: state_d = RUN;

      MCBUSY: begin
        mc_busy = 1'b1;
        if (cnt_q == '0) begin
          // Result is ready this cycle; only a genuine load-use may stall.
          mc_done   = 1'b1;
          stall_raw = load_use;
          state_d   = RUN;
        end else begin
          // A second ex_mc_start here is ignored: cnt/mc_dest not reloaded.
          cnt_d     = cnt_q - CW'(1);
          stall_raw = load_use | mc_hazard | bus.id_mc;
        end
      end

      default: state_d = RUN;
    endcase
  end

  assign stall_cnt_d = (stall_raw && (stall_cnt_q != 16'hFFFF))
                     ? stall_cnt_q + 16'd1 : stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      mc_dest_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mc_dest_q   <= mc_dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The load-use term is combinational from live inputs, so stall/bubble
  // are masked by reset to read 0 the instant reset asserts.
  assign bus.fwd_sel   = fwd_sel;
  assign bus.fwd_store = fwd_store;
  assign bus.stall     = stall_raw & ~reset;
  assign bus.bubble    = stall_raw & ~reset;
  assign bus.mc_busy   = mc_busy;
  assign bus.mc_done   = mc_done;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
